// File: rtl/kbd_disp_fifo.sv
// Scan-code display buffer: queues PS/2 scan codes in a circular FIFO and shows
// each one on disp_code for DISP_TIME cycles, in arrival order.
module kbd_disp_fifo #(
  parameter int unsigned          DATA_W    = 8,
  parameter int unsigned          DEPTH     = 8,
  parameter int unsigned          DISP_TIME = 25000000,
  parameter bit                   HOLD_LAST = 1'b0,
  parameter logic [DATA_W-1:0]    BLANK     = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          scode,
  input  logic                       scode_en,
  input  logic                       flush,
  input  logic                       ovf_clr,
  output logic [DATA_W-1:0]          disp_code,
  output logic                       disp_valid,
  output logic                       disp_new,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned TmrW = $clog2(DISP_TIME);

  localparam logic [TmrW-1:0] TmrLast = TmrW'(DISP_TIME - 1);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);

  typedef enum logic {StIdle, StShow} state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] disp_code_q, disp_code_d;
  logic              disp_valid_q, disp_valid_d;
  logic              disp_new_q, disp_new_d;
  logic              overflow_q, overflow_d;

  logic timer_done, full, pop, push, drop, mem_we;

  // Handshake decode: a pop frees a slot, so a write into a full FIFO may proceed.
  always_comb begin
    timer_done = (timer_q == TmrLast);
    full       = (level_q == LvlFull);
    // An empty FIFO never pops, even if a write lands this cycle (no bypass).
    pop        = (level_q != '0) && ((state_q == StIdle) || timer_done);
    push       = scode_en && (!full || pop);
    drop       = scode_en && full && !pop;
    mem_we     = push && !flush;
  end

  // Next-state for pointers, occupancy, display FSM and overflow flag.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    timer_d      = timer_q;
    state_d      = state_q;
    disp_code_d  = disp_code_q;
    disp_valid_d = disp_valid_q;
    disp_new_d   = 1'b0;
    overflow_d   = overflow_q;

    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      timer_d      = '0;
      state_d      = StIdle;
      disp_code_d  = BLANK;
      disp_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);

      unique case ({push, pop})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase

      if (pop) begin
        disp_code_d  = mem_q[rd_ptr_q];
        disp_valid_d = 1'b1;
        disp_new_d   = 1'b1;
        timer_d      = '0;
        state_d      = StShow;
      end else if (state_q == StShow) begin
        if (timer_done) begin
          disp_valid_d = 1'b0;
          timer_d      = '0;
          state_d      = StIdle;
          if (!HOLD_LAST) disp_code_d = BLANK;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end

      // A drop coinciding with a clear must leave the flag set.
      if (drop)         overflow_d = 1'b1;
      else if (ovf_clr) overflow_d = 1'b0;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= scode;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      timer_q      <= '0;
      state_q      <= StIdle;
      disp_code_q  <= BLANK;
      disp_valid_q <= 1'b0;
      disp_new_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      timer_q      <= timer_d;
      state_q      <= state_d;
      disp_code_q  <= disp_code_d;
      disp_valid_q <= disp_valid_d;
      disp_new_q   <= disp_new_d;
      overflow_q   <= overflow_d;
    end
  end

  assign disp_code  = disp_code_q;
  assign disp_valid = disp_valid_q;
  assign disp_new   = disp_new_q;
  assign level      = level_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_kbd_disp_fifo.sv
// Directed bench for kbd_disp_fifo: DEPTH=4, DISP_TIME=16, BLANK=8'hEE.
// Two instances share stimulus; the second keeps the last code (HOLD_LAST=1).
module tb_kbd_disp_fifo;

  localparam logic [7:0] Blank = 8'hEE;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] scode;
  logic       scode_en, flush, ovf_clr;

  logic [7:0] disp_code, h_code;
  logic       disp_valid, disp_new, overflow;
  logic       h_valid, h_new, h_ovf;
  logic [2:0] level, h_level;

  int n_total = 0;
  int n_pass  = 0;

  kbd_disp_fifo #(
    .DATA_W(8), .DEPTH(4), .DISP_TIME(16), .HOLD_LAST(1'b0), .BLANK(Blank)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scode(scode), .scode_en(scode_en), .flush(flush),
    .ovf_clr(ovf_clr), .disp_code(disp_code), .disp_valid(disp_valid),
    .disp_new(disp_new), .level(level), .overflow(overflow)
  );

  kbd_disp_fifo #(
    .DATA_W(8), .DEPTH(4), .DISP_TIME(16), .HOLD_LAST(1'b1), .BLANK(Blank)
  ) dut_h (
    .clk(clk), .rst_n(rst_n), .scode(scode), .scode_en(scode_en), .flush(flush),
    .ovf_clr(ovf_clr), .disp_code(h_code), .disp_valid(h_valid),
    .disp_new(h_new), .level(h_level), .overflow(h_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [7:0]  code;
    logic        fl;
    logic        clr;
    int unsigned n;       // cycles to run; inputs applied only in the first
    logic [7:0]  e_code;
    logic        e_valid;
    logic        e_new;
    logic [2:0]  e_level;
    logic        e_ovf;
    logic [7:0]  e_hcode; // expected disp_code of the HOLD_LAST instance
  } vec_t;

  vec_t vecs[$];

  logic [7:0] t2_codes [10];
  int         t2_push  [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [7:0] c, input logic v,
                          input logic nw, input logic [2:0] l, input logic o,
                          input logic [7:0] hc);
    chk({tag, " code"},    disp_code, c);
    chk({tag, " valid"},   disp_valid, v);
    chk({tag, " new"},     disp_new, nw);
    chk({tag, " level"},   level, l);
    chk({tag, " ovf"},     overflow, o);
    chk({tag, " h_code"},  h_code, hc);
    chk({tag, " h_valid"}, h_valid, v);
    chk({tag, " h_new"},   h_new, nw);
    chk({tag, " h_level"}, h_level, l);
    chk({tag, " h_ovf"},   h_ovf, o);
  endtask

  initial begin
    rst_n = 1'b0; scode = '0; scode_en = 1'b0; flush = 1'b0; ovf_clr = 1'b0;

    // Single code, then HOLD_LAST behaviour on the second instance
    vecs.push_back('{1, 8'h1C, 0, 0, 1,  Blank, 0, 0, 1, 0, Blank});
    vecs.push_back('{0, 8'h00, 0, 0, 1,  8'h1C, 1, 1, 0, 0, 8'h1C});
    vecs.push_back('{0, 8'h00, 0, 0, 1,  8'h1C, 1, 0, 0, 0, 8'h1C});
    vecs.push_back('{0, 8'h00, 0, 0, 14, 8'h1C, 1, 0, 0, 0, 8'h1C});
    vecs.push_back('{0, 8'h00, 0, 0, 1,  Blank, 0, 0, 0, 0, 8'h1C});
    // Overflow: six consecutive codes, the sixth is dropped
    vecs.push_back('{1, 8'hA0, 0, 0, 1,  Blank, 0, 0, 1, 0, 8'h1C});
    vecs.push_back('{1, 8'hA1, 0, 0, 1,  8'hA0, 1, 1, 1, 0, 8'hA0});
    vecs.push_back('{1, 8'hA2, 0, 0, 1,  8'hA0, 1, 0, 2, 0, 8'hA0});
    vecs.push_back('{1, 8'hA3, 0, 0, 1,  8'hA0, 1, 0, 3, 0, 8'hA0});
    vecs.push_back('{1, 8'hA4, 0, 0, 1,  8'hA0, 1, 0, 4, 0, 8'hA0});
    vecs.push_back('{1, 8'hA5, 0, 0, 1,  8'hA0, 1, 0, 4, 1, 8'hA0});
    vecs.push_back('{0, 8'h00, 0, 0, 11, 8'hA0, 1, 0, 4, 1, 8'hA0});
    vecs.push_back('{0, 8'h00, 0, 0, 1,  8'hA1, 1, 1, 3, 1, 8'hA1});
    vecs.push_back('{0, 8'h00, 0, 1, 1,  8'hA1, 1, 0, 3, 0, 8'hA1});
    vecs.push_back('{0, 8'h00, 0, 0, 15, 8'hA2, 1, 1, 2, 0, 8'hA2});
    vecs.push_back('{0, 8'h00, 0, 0, 16, 8'hA3, 1, 1, 1, 0, 8'hA3});
    vecs.push_back('{0, 8'h00, 0, 0, 16, 8'hA4, 1, 1, 0, 0, 8'hA4});
    vecs.push_back('{0, 8'h00, 0, 0, 16, Blank, 0, 0, 0, 0, 8'hA4});
    // Full FIFO: write with simultaneous pop accepted; drop beats ovf_clr
    vecs.push_back('{1, 8'hB0, 0, 0, 1,  Blank, 0, 0, 1, 0, 8'hA4});
    vecs.push_back('{1, 8'hB1, 0, 0, 1,  8'hB0, 1, 1, 1, 0, 8'hB0});
    vecs.push_back('{1, 8'hB2, 0, 0, 1,  8'hB0, 1, 0, 2, 0, 8'hB0});
    vecs.push_back('{1, 8'hB3, 0, 0, 1,  8'hB0, 1, 0, 3, 0, 8'hB0});
    vecs.push_back('{1, 8'hB4, 0, 0, 1,  8'hB0, 1, 0, 4, 0, 8'hB0});
    vecs.push_back('{0, 8'h00, 0, 0, 12, 8'hB0, 1, 0, 4, 0, 8'hB0});
    vecs.push_back('{1, 8'hB5, 0, 0, 1,  8'hB1, 1, 1, 4, 0, 8'hB1});
    vecs.push_back('{1, 8'hB6, 0, 1, 1,  8'hB1, 1, 0, 4, 1, 8'hB1});
    // Flush mid-window at level 2; write in flush cycle discarded; overflow kept
    vecs.push_back('{0, 8'h00, 0, 0, 31, 8'hB3, 1, 1, 2, 1, 8'hB3});
    vecs.push_back('{0, 8'h00, 0, 0, 3,  8'hB3, 1, 0, 2, 1, 8'hB3});
    vecs.push_back('{1, 8'hC9, 1, 0, 1,  Blank, 0, 0, 0, 1, Blank});
    vecs.push_back('{0, 8'h00, 0, 0, 2,  Blank, 0, 0, 0, 1, Blank});
    vecs.push_back('{0, 8'h00, 0, 1, 1,  Blank, 0, 0, 0, 0, Blank});

    t2_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
    t2_push  = '{0, 1, 2, 3, 23, 43, 63, 83, 103, 123};

    // Reset state, checked while reset is still asserted and after release
    #12;
    chk_outs("reset", Blank, 0, 0, 0, 0, Blank);
    rst_n = 1'b1;
    step();
    chk_outs("post_reset", Blank, 0, 0, 0, 0, Blank);

    for (int i = 0; i < vecs.size(); i++) begin
      scode_en = vecs[i].en; scode = vecs[i].code;
      flush = vecs[i].fl;    ovf_clr = vecs[i].clr;
      step();
      scode_en = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
      for (int j = 1; j < int'(vecs[i].n); j++) step();
      chk_outs($sformatf("v%0d", i), vecs[i].e_code, vecs[i].e_valid, vecs[i].e_new,
               vecs[i].e_level, vecs[i].e_ovf, vecs[i].e_hcode);
    end

    // Burst with pointer wrap: ten codes shown back-to-back, 16 cycles each
    begin : burst
      int k;
      int gaps;
      int peak;
      k = 0; gaps = 0; peak = 0;
      for (int e = 0; e <= 161; e++) begin
        scode_en = 1'b0;
        if (k < 10 && t2_push[k] == e) begin
          scode_en = 1'b1;
          scode    = t2_codes[k];
          k++;
        end
        step();
        if (int'(level) > peak) peak = int'(level);
        if (e >= 1 && e <= 160) begin
          if (!disp_valid) gaps++;
          if ((e - 1) % 16 == 0) begin
            chk($sformatf("burst code%0d", (e - 1) / 16), disp_code, t2_codes[(e - 1) / 16]);
            chk($sformatf("burst new%0d", (e - 1) / 16), disp_new, 1'b1);
          end else if (disp_new) begin
            gaps++;
          end
        end
      end
      scode_en = 1'b0;
      chk("burst gaps", gaps, 0);
      chk("burst peak level", peak, 3);
      chk("burst end valid", disp_valid, 1'b0);
      chk("burst end code", disp_code, Blank);
    end

    // Asynchronous reset mid-window with a full FIFO and overflow set
    for (int i = 0; i < 6; i++) begin
      scode_en = 1'b1;
      scode    = 8'h50 + 8'(i);
      step();
    end
    scode_en = 1'b0;
    step(); step(); step();
    chk("pre_reset ovf", overflow, 1'b1);
    chk("pre_reset level", level, 3'd4);
    chk("pre_reset code", disp_code, 8'h50);
    #2 rst_n = 1'b0;
    #1;
    chk_outs("async_reset", Blank, 0, 0, 0, 0, Blank);
    @(negedge clk);
    rst_n = 1'b1;
    step(); step(); step();
    chk_outs("after_reset", Blank, 0, 0, 0, 0, Blank);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
